// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - PC owner, in-order fetch issue, prefetch FIFO and redirect squash
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {S_FETCH, S_HALT} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic          r_halted;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc4   [DEPTH];
    logic [PW-1:0] r_fifo_wr;
    logic [PW-1:0] r_fifo_rd;
    logic [CW-1:0] r_fifo_cnt;
    logic [31:0]   r_tag        [DEPTH];
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic w_fetch;
    logic w_redirect;
    logic w_misalign;
    logic w_room;
    logic w_issue;
    logic w_push;
    logic w_pop;

    assign w_fetch    = (r_state == S_FETCH);
    assign w_redirect = w_fetch & redirect;
    assign w_misalign = w_redirect & (redirect_pc[1:0] != 2'b00);
    // Occupancy plus in-flight is capped so every response is guaranteed a FIFO slot.
    assign w_room     = ({1'b0, r_fifo_cnt} + {1'b0, r_outstanding}) < DEPTH_W;
    assign w_issue    = ~reset & w_fetch & ~redirect & w_room;
    assign w_push     = imem_rvalid & w_fetch & ~w_redirect & (r_drop_cnt == '0);
    assign w_pop      = id_valid & id_ready;

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign id_valid    = w_fetch & (r_fifo_cnt != '0);
    assign id_instr    = r_fifo_instr[r_fifo_rd];
    assign id_pc_plus4 = r_fifo_pc4[r_fifo_rd];
    assign halted      = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
            r_fifo_cnt    <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc4[i]   <= '0;
                r_tag[i]        <= '0;
            end
        end else begin
            if (w_issue) begin
                r_tag[r_tag_wr] <= r_pc;
                r_tag_wr        <= r_tag_wr + PW'(1);
                r_pc            <= r_pc + 32'd4;
            end
            if (imem_rvalid) begin
                r_tag_rd <= r_tag_rd + PW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(imem_rvalid);

            // A response in the redirect cycle is itself stale, hence the subtraction.
            if (w_redirect) begin
                r_drop_cnt <= r_outstanding - CW'(imem_rvalid);
            end else if (imem_rvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end

            if (w_redirect) begin
                r_fifo_cnt <= '0;
                r_fifo_wr  <= '0;
                r_fifo_rd  <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_instr[r_fifo_wr] <= imem_rdata;
                    r_fifo_pc4[r_fifo_wr]   <= r_tag[r_tag_rd] + 32'd4;
                    r_fifo_wr               <= r_fifo_wr + PW'(1);
                end
                if (w_pop) begin
                    r_fifo_rd <= r_fifo_rd + PW'(1);
                end
                r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
            end

            if (w_redirect) begin
                r_pc <= redirect_pc;
            end
            if (w_misalign) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - vector table, corner sequences and random run against a program-order model
module tb_fetch_prefetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        halted;

    fetch_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    pend_t       pend[$];
    vec_t        vt[6];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    int          deliv_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] exp_pc, exp_fetch;
    logic        halted_m = 1'b0;
    logic [31:0] last_pc4, last_instr;
    logic        s_req, s_valid, s_halted, s_rvalid;
    logic [31:0] s_addr, s_instr, s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);
        #1;
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_valid", 32'(id_valid), 32'd0);
        chk("reset_instr", id_instr, 32'd0);
        chk("reset_pc4", id_pc_plus4, 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        pend.delete();
        last_due  = -1;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        halted_m  = 1'b0;
        cyc       = 0;
    endtask

    task automatic tick(input logic redir, input logic [31:0] rpc, input logic rdy);
        int lat, due;
        @(negedge clk);
        reset = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        redirect = redir; redirect_pc = rpc; id_ready = rdy;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
        s_instr = id_instr; s_pc4 = id_pc_plus4; s_halted = halted; s_rvalid = imem_rvalid;
        chk("halted_flag", 32'(s_halted), 32'(halted_m));
        if (halted_m) begin
            chk("halt_req", 32'(s_req), 32'd0);
            chk("halt_valid", 32'(s_valid), 32'd0);
        end else begin
            if (s_valid && rdy) begin
                chk("deliv_pc4", s_pc4, exp_pc + 32'd4);
                chk("deliv_instr", s_instr, mem_word(exp_pc));
                exp_pc     = exp_pc + 32'd4;
                deliv_cnt++;
                last_pc4   = s_pc4;
                last_instr = s_instr;
            end
            if (redir) begin
                chk("req_in_redirect", 32'(s_req), 32'd0);
                exp_pc    = rpc;
                exp_fetch = rpc;
                if (rpc[1:0] != 2'b00) halted_m = 1'b1;
            end else if (s_req) begin
                chk("fetch_addr", s_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        if (s_req) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: s_addr, due: due});
            req_cnt++;
            chk("inflight_cap", 32'(pend.size() <= DEPTH), 32'd1);
        end
        cyc++;
    endtask

    task automatic wait_deliv(input string name);
        int start;
        bit got;
        start = deliv_cnt;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick(1'b0, 32'd0, 1'b1);
            if (deliv_cnt != start) got = 1'b1;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_pc4 [2];
        int          base;
        int          rnd_start;
        logic        rd;
        logic [31:0] tgt;

        // 1-cycle memory, decode always ready, straight from reset.
        vt[0] = '{req: 1'b1, addr: 32'h00, valid: 1'b0, instr: 32'h0,         pc4: 32'h0};
        vt[1] = '{req: 1'b1, addr: 32'h04, valid: 1'b0, instr: 32'h0,         pc4: 32'h0};
        vt[2] = '{req: 1'b1, addr: 32'h08, valid: 1'b1, instr: 32'h1000_0000, pc4: 32'h04};
        vt[3] = '{req: 1'b1, addr: 32'h0C, valid: 1'b1, instr: 32'h1000_0001, pc4: 32'h08};
        vt[4] = '{req: 1'b1, addr: 32'h10, valid: 1'b1, instr: 32'h1000_0002, pc4: 32'h0C};
        vt[5] = '{req: 1'b1, addr: 32'h14, valid: 1'b1, instr: 32'h1000_0003, pc4: 32'h10};

        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'd0, 1'b1);
            chk($sformatf("vec%0d_req", i), 32'(s_req), 32'(vt[i].req));
            chk($sformatf("vec%0d_addr", i), s_addr, vt[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vt[i].valid));
            if (vt[i].valid) begin
                chk($sformatf("vec%0d_instr", i), s_instr, vt[i].instr);
                chk($sformatf("vec%0d_pc4", i), s_pc4, vt[i].pc4);
            end
        end

        // Backpressure: exactly DEPTH requests, then stall.
        do_reset();
        req_cnt = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 1'b0);
        chk("bp_req_count", 32'(req_cnt), 32'(DEPTH));
        chk("bp_req_stalled", 32'(s_req), 32'd0);
        chk("bp_head_valid", 32'(s_valid), 32'd1);
        chk("bp_head_pc4", s_pc4, 32'h4);
        base = deliv_cnt;
        for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b1);
        chk("bp_release_count", 32'(deliv_cnt - base), 32'd4);
        chk("bp_release_last", last_pc4, 32'h10);

        // Redirect with three requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1);
        tick(1'b1, 32'h40, 1'b1);
        chk("r3_rvalid_in_redirect", 32'(s_rvalid), 32'd1);
        tick(1'b0, 32'd0, 1'b1);
        chk("r3_fifo_empty", 32'(s_valid), 32'd0);
        chk("r3_resume_addr", s_addr, 32'h40);
        wait_deliv("r3_deliv_timeout");
        chk("r3_first_pc4", last_pc4, 32'h44);
        chk("r3_first_instr", last_instr, mem_word(32'h40));

        // Redirect coincident with a pop and a response.
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b1);
        base = deliv_cnt;
        tick(1'b1, 32'h80, 1'b1);
        chk("co_pop", 32'(deliv_cnt - base), 32'd1);
        chk("co_popped_pc4", last_pc4, 32'h0C);
        chk("co_rvalid", 32'(s_rvalid), 32'd1);
        tick(1'b0, 32'd0, 1'b1);
        chk("co_flushed", 32'(s_valid), 32'd0);
        chk("co_resume_req", 32'(s_req), 32'd1);
        chk("co_resume_addr", s_addr, 32'h80);
        wait_deliv("co_deliv_timeout");
        chk("co_first_pc4", last_pc4, 32'h84);

        // Misaligned redirect halts until reset.
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 32'd0, 1'b1);
        tick(1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 1'b1);
        chk("mis_halted", 32'(s_halted), 32'd1);
        do_reset();
        tick(1'b0, 32'd0, 1'b1);
        chk("mis_restart_req", 32'(s_req), 32'd1);
        chk("mis_restart_addr", s_addr, RESET_PC);
        chk("mis_restart_halted", 32'(s_halted), 32'd0);

        // Wrap from the top of the address space.
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1);
        tick(1'b1, 32'hFFFF_FFFC, 1'b1);
        tick(1'b0, 32'd0, 1'b1);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        tick(1'b0, 32'd0, 1'b1);
        chk("wrap_addr1", s_addr, 32'h0);
        wait_deliv("wrap_deliv0_timeout");
        wrap_pc4[0] = last_pc4;
        wait_deliv("wrap_deliv1_timeout");
        wrap_pc4[1] = last_pc4;
        chk("wrap_pc4_0", wrap_pc4[0], 32'h0);
        chk("wrap_pc4_1", wrap_pc4[1], 32'h4);

        // Random latency, backpressure and aligned redirects.
        do_reset();
        lat_min = 1; lat_max = 4;
        rnd_start = deliv_cnt;
        for (int i = 0; i < 3000; i++) begin
            rd  = ($urandom_range(3, 0) != 0);
            tgt = 32'($urandom_range(1023, 0)) << 2;
            if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF0 + (tgt & 32'hC);
            tick(($urandom_range(19, 0) == 0), tgt, rd);
        end
        chk("rand_progress", 32'((deliv_cnt - rnd_start) > 500), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
